tlb_asid: RTL and testbench
===========================

Name: tlb_asid

Overview:
- Parametrised, fully-associative, ASID-tagged TLB; next generation of the per-side I/D TLB.
- Sits between the fetch/LSU address path and the page walker.
- Adds over the previous TLB: ASID and global-bit matching, tree-PLRU victim selection with invalid-first fill, and a selective sfence.vma flush FSM (by VA, by ASID, or both).
- Lookup latency stays at 1 cycle, registered.

Parameters:
N, 8, entry count; power of two, 2..64
ASID_W, 16, ASID tag width
ISIDE, 0, 1 = instruction-side instance (debug labelling only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
priv  in  2  current privilege level (passthrough qualifier, unused for match)
active  in  1  translation enabled; when 0, pa=va and hit=1
req  in  1  lookup valid
va  in  64  lookup virtual address
asid  in  ASID_W  current ASID (satp.ASID)
pa  out  PA_WIDTH  translated physical address
hit  out  1  registered lookup hit
dirty, readable, writable, executable, user  out  1 each  permissions of the hit entry
zero_page  out  1  va[39:12]==0
replace  in  1  page-walk fill strobe
replace_ready  out  1  fill accepted this cycle (= FSM in IDLE)
replace_va  in  64  VA of the fill
replace_asid  in  ASID_W  ASID of the fill
page_walk_rsp  in  page_walk_rsp_t  walker response (paddr, fault, gbl, pgsize, permission bits)
flush_req  in  1  sfence.vma request
flush_va_en  in  1  restrict the flush to matching VA
flush_va  in  64  flush VA
flush_asid_en  in  1  restrict the flush to matching ASID
flush_asid  in  ASID_W  flush ASID
flush_ack  out  1  one-cycle pulse when the flush completes
tlb_hits, tlb_accesses  out  64 each  performance counters

Behaviour:
- Reset (async, reset==0):
  - All valid bits cleared; PLRU bits cleared; FSM set to IDLE.
  - Outputs: hit=0, pa=0, all permission outputs=0, zero_page=0, flush_ack=0, counters=0.
- Match condition for entry i:
  - valid[i] & (gbl[i] | tag_asid[i]==asid) & VA-tag compare by pgsize.
  - pgsize encoding: 0=1G [39:30], 1=2M [39:21], 2=4K [39:12], 3=64K [39:16].
- Multiple hits select the lowest index.
- PA formation: page base from paddr[63:12] concatenated with the VA offset for the entry's pgsize.
- Lookup results (hit, pa, permissions) are registered the cycle after req.
  - hit = active ? (req & match & FSM==IDLE) : 1.
  - When active=0: pa = va[PA_WIDTH-1:0].
- PLRU: a tree of N-1 bits, updated on every cycle with req & active & hit, pointing away from the hit entry.
- Fill, when replace & replace_ready & ~page_walk_rsp.fault:
  - Victim = lowest invalid entry if any exist, else the PLRU victim.
  - Write the tag (replace_va[39:12], replace_asid, gbl, pgsize), paddr[63:12] and permissions; set valid; touch PLRU as an access to the victim.
- A fill with fault=1 writes nothing and leaves PLRU unchanged.
- A fill and a lookup hit in the same cycle: the fill's PLRU touch wins.
- Flush FSM: IDLE -> FLUSH -> DONE -> IDLE.
  - IDLE: flush_req moves to FLUSH and latches flush_va_en, flush_va, flush_asid_en, flush_asid.
  - FLUSH (1 cycle): clear valid[i] for every entry satisfying all enabled conditions:
    - VA condition: the entry's tag matches flush_va at the entry's pgsize.
    - ASID condition: tag_asid==flush_asid & ~gbl.
    - With neither enable set, every entry is cleared, global entries included.
  - DONE: assert flush_ack for 1 cycle, then return to IDLE.
- While not IDLE: replace_ready=0, lookups report a miss, and further flush_req is ignored. The requester holds the fill until replace_ready.
- A flush_req in IDLE in the same cycle as an accepted fill: the fill is written first, then the flush evaluates it in FLUSH.
- Reset mid-flush returns the FSM to IDLE with no flush_ack.

Optional Feature:
TLB_PERF_CNT_EN:
- Defined:
  - tlb_accesses increments on active & req.
  - tlb_hits increments on active & req & match (64-bit, wraps).
- Undefined: both counters are tied to 0 and no counter flops exist.

Decomposition:
- machine.vh / rob.vh: page_walk_rsp_t, PA_WIDTH, and pgsize localparams (PG_1G=0, PG_2M=1, PG_4K=2, PG_64K=3).
- Reused: existing find_first_set for hit selection and for invalid-entry selection.
- One new sub-module, plru_tree (parameter N): ports touch_en, touch_idx, victim_idx; async reset.

Test Plan:
1. Reset, then fill 4K va=0x12345000, asid=5, paddr=0x8000_0000 -> lookup va=0x12345ABC with asid=5 gives hit=1, pa=0x8000_0ABC; the same lookup with asid=6 gives hit=0.
2. Fill 2M with gbl=1, asid=3 -> lookup with asid=7 at va+0x1F_FFF0 hits; flush_asid_en=1, flush_asid=3 leaves it valid; a full flush clears it and flush_ack pulses exactly 2 cycles after flush_req.
3. N=4: fill entries 0-3, then hit entries 0, 2, 1 in order -> the next fill replaces entry 3; a fault=1 fill writes nothing and leaves the victim unchanged.
4. Assert flush_req and replace in the same cycle -> the new entry is written and then cleared by a matching VA flush; replace_ready=0 for the 2 FSM cycles.
5. Drive reset low during FLUSH -> all outputs 0, flush_ack never asserted, subsequent lookup misses.
6. With TLB_PERF_CNT_EN: 10 requests with 7 hits -> tlb_accesses=10, tlb_hits=7; without the macro both read 0.

Source files
------------

// File: rtl/tlb_asid_pkg.sv
// Shared types and helpers for the ASID-tagged TLB: walker response, entry
// payload, page-size encodings, flush FSM states and tag/offset masks.
package tlb_asid_pkg;

  localparam int unsigned PA_WIDTH = 56;
  localparam int unsigned PPN_W    = PA_WIDTH - 12;
  localparam int unsigned VPN_W    = 28;  // va[39:12]

  localparam logic [1:0] PG_1G  = 2'd0;
  localparam logic [1:0] PG_2M  = 2'd1;
  localparam logic [1:0] PG_4K  = 2'd2;
  localparam logic [1:0] PG_64K = 2'd3;

  typedef struct packed {
    logic dirty;
    logic readable;
    logic writable;
    logic executable;
    logic user;
  } tlb_perm_t;

  typedef struct packed {
    logic [63:0] paddr;
    logic        fault;
    logic        gbl;
    logic [1:0]  pgsize;
    tlb_perm_t   perm;
  } page_walk_rsp_t;

  typedef struct packed {
    logic [VPN_W-1:0] vpn;
    logic             gbl;
    logic [1:0]       pgsize;
    logic [PPN_W-1:0] ppn;
    tlb_perm_t        perm;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } flush_state_e;

  // VPN bits (va[39:12]) that take part in a tag compare for a page size
  function automatic logic [VPN_W-1:0] vpn_mask(input logic [1:0] pgsize);
    case (pgsize)
      PG_1G:   vpn_mask = 28'hFFC_0000;
      PG_2M:   vpn_mask = 28'hFFF_FE00;
      PG_64K:  vpn_mask = 28'hFFF_FFF0;
      default: vpn_mask = 28'hFFF_FFFF;
    endcase
  endfunction

  // Physical-address bits taken from the VA offset for a page size
  function automatic logic [PA_WIDTH-1:0] pa_off_mask(input logic [1:0] pgsize);
    case (pgsize)
      PG_1G:   pa_off_mask = PA_WIDTH'(64'h3FFF_FFFF);
      PG_2M:   pa_off_mask = PA_WIDTH'(64'h001F_FFFF);
      PG_64K:  pa_off_mask = PA_WIDTH'(64'h0000_FFFF);
      default: pa_off_mask = PA_WIDTH'(64'h0000_0FFF);
    endcase
  endfunction

  // Index of the lowest set bit (0 when none is set)
  function automatic logic [5:0] find_first_set(input logic [63:0] vec);
    find_first_set = '0;
    for (int i = 63; i >= 0; i--) begin
      if (vec[i]) find_first_set = 6'(i);
    end
  endfunction

endpackage

// File: rtl/tlb_asid_plru_tree.sv
// Tree pseudo-LRU over N ways (N-1 node bits, heap order, root at index 1).
// A node bit of 0 points the victim search to the lower half.
module tlb_asid_plru_tree #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 touch_en,
  input  logic [$clog2(N)-1:0] touch_idx,
  output logic [$clog2(N)-1:0] victim_idx
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:1]     tree_q;
  logic [N-1:1]     tree_d;
  logic [IDX_W-1:0] node_t;
  logic [IDX_W-1:0] node_v;

  // Touch: walk root-to-leaf along touch_idx, pointing each node away from it
  always_comb begin
    tree_d = tree_q;
    node_t = IDX_W'(1);
    if (touch_en) begin
      for (int l = 0; l < int'(IDX_W); l++) begin
        tree_d[node_t] = ~touch_idx[IDX_W-1-l];
        node_t         = IDX_W'({node_t, touch_idx[IDX_W-1-l]});
      end
    end
  end

  // Victim: follow the node pointers from the root
  always_comb begin
    victim_idx = '0;
    node_v     = IDX_W'(1);
    for (int l = 0; l < int'(IDX_W); l++) begin
      victim_idx[IDX_W-1-l] = tree_q[node_v];
      node_v                = IDX_W'({node_v, tree_q[node_v]});
    end
  end

  // Tree state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tree_q <= '0;
    else        tree_q <= tree_d;
  end

endmodule

// File: rtl/tlb_asid.sv
// Fully-associative ASID-tagged TLB with tree-PLRU replacement (invalid-first
// fill) and a selective sfence.vma flush FSM. Lookup results are registered.
// Build option: TLB_PERF_CNT_EN enables the tlb_hits/tlb_accesses counters;
// without it both read 0.
module tlb_asid
  import tlb_asid_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned ASID_W = 16,
  parameter int unsigned ISIDE  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          priv,
  input  logic                active,
  input  logic                req,
  input  logic [63:0]         va,
  input  logic [ASID_W-1:0]   asid,
  output logic [PA_WIDTH-1:0] pa,
  output logic                hit,
  output logic                dirty,
  output logic                readable,
  output logic                writable,
  output logic                executable,
  output logic                user,
  output logic                zero_page,
  input  logic                replace,
  output logic                replace_ready,
  input  logic [63:0]         replace_va,
  input  logic [ASID_W-1:0]   replace_asid,
  input  page_walk_rsp_t      page_walk_rsp,
  input  logic                flush_req,
  input  logic                flush_va_en,
  input  logic [63:0]         flush_va,
  input  logic                flush_asid_en,
  input  logic [ASID_W-1:0]   flush_asid,
  output logic                flush_ack,
  output logic [63:0]         tlb_hits,
  output logic [63:0]         tlb_accesses
);

  localparam int unsigned IDX_W = $clog2(N);

  tlb_entry_t        ent_q  [N];
  logic [ASID_W-1:0] asid_q [N];
  logic [N-1:0]      valid_q;
  logic [N-1:0]      valid_d;

  flush_state_e      state_q;
  flush_state_e      state_d;
  logic              flush_ack_d;
  logic              idle;

  logic              fva_en_q;
  logic [VPN_W-1:0]  fva_q;
  logic              fasid_en_q;
  logic [ASID_W-1:0] fasid_q;

  logic [N-1:0]      match_vec;
  logic [N-1:0]      flush_clr;
  logic              match_any;
  logic [IDX_W-1:0]  hit_idx;
  tlb_entry_t        hit_ent;
  logic [PA_WIDTH-1:0] lookup_pa_c;
  logic              lookup_hit_c;

  logic              fill_c;
  logic              any_invalid;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim_c;
  logic [IDX_W-1:0]  plru_victim;
  logic              plru_touch_c;
  logic [IDX_W-1:0]  plru_idx_c;
  tlb_entry_t        new_ent_c;

  tlb_perm_t         perm_q;

  assign idle          = (state_q == ST_IDLE);
  assign replace_ready = idle;

  // Flush FSM next-state; the ack register is set on entry to DONE
  always_comb begin
    state_d     = state_q;
    flush_ack_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: begin
        state_d     = ST_DONE;
        flush_ack_d = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush FSM state, ack pulse and latched flush qualifiers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      flush_ack  <= 1'b0;
      fva_en_q   <= 1'b0;
      fva_q      <= '0;
      fasid_en_q <= 1'b0;
      fasid_q    <= '0;
    end else begin
      state_q   <= state_d;
      flush_ack <= flush_ack_d;
      if (idle && flush_req) begin
        fva_en_q   <= flush_va_en;
        fva_q      <= flush_va[39:12];
        fasid_en_q <= flush_asid_en;
        fasid_q    <= flush_asid;
      end
    end
  end

  // Per-entry lookup match and flush selection
  always_comb begin
    match_vec = '0;
    flush_clr = '0;
    for (int i = 0; i < int'(N); i++) begin
      match_vec[i] = valid_q[i]
                   & (ent_q[i].gbl | (asid_q[i] == asid))
                   & (((ent_q[i].vpn ^ va[39:12]) & vpn_mask(ent_q[i].pgsize)) == '0);
      flush_clr[i] = (!fva_en_q
                      | (((ent_q[i].vpn ^ fva_q) & vpn_mask(ent_q[i].pgsize)) == '0))
                   & (!fasid_en_q | ((asid_q[i] == fasid_q) & !ent_q[i].gbl));
    end
  end

  assign match_any    = |match_vec;
  assign hit_idx      = IDX_W'(find_first_set(64'(match_vec)));
  assign hit_ent      = ent_q[hit_idx];
  assign lookup_hit_c = req & match_any & idle;
  assign lookup_pa_c  = ({hit_ent.ppn, 12'h000} & ~pa_off_mask(hit_ent.pgsize))
                      | (va[PA_WIDTH-1:0] & pa_off_mask(hit_ent.pgsize));

  // Fill victim: lowest invalid entry first, otherwise the PLRU choice
  assign fill_c      = replace & idle & ~page_walk_rsp.fault;
  assign any_invalid = ~&valid_q;
  assign free_idx    = IDX_W'(find_first_set(64'(~valid_q)));
  assign victim_c    = any_invalid ? free_idx : plru_victim;

  // PLRU touch; a fill takes priority over a same-cycle lookup hit
  assign plru_touch_c = fill_c | (active & lookup_hit_c);
  assign plru_idx_c   = fill_c ? victim_c : hit_idx;

  tlb_asid_plru_tree #(.N(N)) u_plru (
    .clk        (clk),
    .reset      (reset),
    .touch_en   (plru_touch_c),
    .touch_idx  (plru_idx_c),
    .victim_idx (plru_victim)
  );

  // Entry payload built from the walker response
  always_comb begin
    new_ent_c        = '0;
    new_ent_c.vpn    = replace_va[39:12];
    new_ent_c.gbl    = page_walk_rsp.gbl;
    new_ent_c.pgsize = page_walk_rsp.pgsize;
    new_ent_c.ppn    = page_walk_rsp.paddr[PA_WIDTH-1:12];
    new_ent_c.perm   = page_walk_rsp.perm;
  end

  // Valid bits: set on fill, cleared selectively in FLUSH
  always_comb begin
    valid_d = valid_q;
    if (fill_c) valid_d[victim_c] = 1'b1;
    if (state_q == ST_FLUSH) valid_d = valid_q & ~flush_clr;
  end

  // Valid register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Entry storage; contents are qualified by valid so need no reset
  always_ff @(posedge clk) begin
    if (fill_c) begin
      ent_q[victim_c]  <= new_ent_c;
      asid_q[victim_c] <= replace_asid;
    end
  end

  // Registered lookup result; translation-off passes the VA straight through
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit       <= 1'b0;
      pa        <= '0;
      perm_q    <= '0;
      zero_page <= 1'b0;
    end else begin
      zero_page <= (va[39:12] == '0);
      if (!active) begin
        hit    <= 1'b1;
        pa     <= va[PA_WIDTH-1:0];
        perm_q <= '0;
      end else if (lookup_hit_c) begin
        hit    <= 1'b1;
        pa     <= lookup_pa_c;
        perm_q <= hit_ent.perm;
      end else begin
        hit    <= 1'b0;
        pa     <= '0;
        perm_q <= '0;
      end
    end
  end

  assign dirty      = perm_q.dirty;
  assign readable   = perm_q.readable;
  assign writable   = perm_q.writable;
  assign executable = perm_q.executable;
  assign user       = perm_q.user;

`ifdef TLB_PERF_CNT_EN
  logic [63:0] hits_q;
  logic [63:0] acc_q;

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q <= '0;
      acc_q  <= '0;
    end else if (active && req) begin
      acc_q <= acc_q + 64'd1;
      if (match_any) hits_q <= hits_q + 64'd1;
    end
  end

  assign tlb_hits     = hits_q;
  assign tlb_accesses = acc_q;
`else
  assign tlb_hits     = '0;
  assign tlb_accesses = '0;
`endif

  // priv and ISIDE are carried for context only; upper/offset address bits are not tagged
  logic unused_ok;
  assign unused_ok = ^{priv, va, replace_va, flush_va, page_walk_rsp.paddr, 1'(ISIDE)};

endmodule

// File: tb/tb_tlb_asid.sv
// Directed bench for tlb_asid (N=4): lookup/ASID/global match, selective
// flush, PLRU victim choice, fill/flush interaction, reset mid-flush,
// performance counters and translation bypass.
module tb_tlb_asid;
  import tlb_asid_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned ASID_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          priv;
  logic                active;
  logic                req;
  logic [63:0]         va;
  logic [ASID_W-1:0]   asid;
  logic [PA_WIDTH-1:0] pa;
  logic                hit, dirty, readable, writable, executable, user, zero_page;
  logic                replace;
  logic                replace_ready;
  logic [63:0]         replace_va;
  logic [ASID_W-1:0]   replace_asid;
  page_walk_rsp_t      rsp;
  logic                flush_req, flush_va_en, flush_asid_en;
  logic [63:0]         flush_va;
  logic [ASID_W-1:0]   flush_asid;
  logic                flush_ack;
  logic [63:0]         tlb_hits, tlb_accesses;

  int n_cmp = 0;
  int n_err = 0;
  tlb_perm_t fill_perm;
  logic [63:0] exp_acc, exp_hits;

  tlb_asid #(.N(N), .ASID_W(ASID_W), .ISIDE(0)) dut (
    .clk(clk), .reset(reset), .priv(priv), .active(active), .req(req), .va(va),
    .asid(asid), .pa(pa), .hit(hit), .dirty(dirty), .readable(readable),
    .writable(writable), .executable(executable), .user(user), .zero_page(zero_page),
    .replace(replace), .replace_ready(replace_ready), .replace_va(replace_va),
    .replace_asid(replace_asid), .page_walk_rsp(rsp), .flush_req(flush_req),
    .flush_va_en(flush_va_en), .flush_va(flush_va), .flush_asid_en(flush_asid_en),
    .flush_asid(flush_asid), .flush_ack(flush_ack), .tlb_hits(tlb_hits),
    .tlb_accesses(tlb_accesses)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [63:0] lva, input logic [ASID_W-1:0] lasid);
    req  = 1'b1;
    va   = lva;
    asid = lasid;
    tick();
    req = 1'b0;
  endtask

  // Presents a fill and holds it until accepted; reports cycles spent waiting
  task automatic do_fill(input logic [63:0] fva, input logic [ASID_W-1:0] fasid,
                         input logic [63:0] fpa, input logic fgbl, input logic [1:0] fpg,
                         input logic ffault, output int waited);
    replace      = 1'b1;
    replace_va   = fva;
    replace_asid = fasid;
    rsp.paddr    = fpa;
    rsp.fault    = ffault;
    rsp.gbl      = fgbl;
    rsp.pgsize   = fpg;
    rsp.perm     = fill_perm;
    waited = 0;
    while (!replace_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL fill_wait: replace_ready still %0b after %0d cycles, need 1", replace_ready, waited);
    end
    tick();
    replace   = 1'b0;
    rsp.fault = 1'b0;
  endtask

  task automatic do_flush(input logic ven, input logic [63:0] fva,
                          input logic aen, input logic [ASID_W-1:0] fasid);
    flush_req     = 1'b1;
    flush_va_en   = ven;
    flush_va      = fva;
    flush_asid_en = aen;
    flush_asid    = fasid;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %0b need 0", hit); end
    n_cmp++; if (pa !== '0) begin n_err++; $display("FAIL rst_pa: got %h need 0", pa); end
    n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %0b need 0", flush_ack); end
    n_cmp++; if (zero_page !== 1'b0) begin n_err++; $display("FAIL rst_zero_page: got %0b need 0", zero_page); end
    n_cmp++; if ({dirty, readable, writable, executable, user} !== 5'b0) begin n_err++; $display("FAIL rst_perm: got %b need 00000", {dirty, readable, writable, executable, user}); end
    n_cmp++; if (tlb_accesses !== 64'd0 || tlb_hits !== 64'd0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d need 0/0", tlb_accesses, tlb_hits); end
    n_cmp++; if (replace_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b need 1", replace_ready); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_lookup();
    int w;
    fill_perm = '{dirty: 1'b1, readable: 1'b1, writable: 1'b0, executable: 1'b1, user: 1'b0};
    do_fill(64'h1234_5000, 16'd5, 64'h8000_0000, 1'b0, PG_4K, 1'b0, w);
    do_lookup(64'h1234_5ABC, 16'd5);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t1_hit: got %0b need 1", hit); end
    n_cmp++; if (pa !== 56'h8000_0ABC) begin n_err++; $display("FAIL t1_pa: got %h need 80000abc", pa); end
    n_cmp++; if ({dirty, readable, writable, executable, user} !== 5'b11010) begin n_err++; $display("FAIL t1_perm: got %b need 11010", {dirty, readable, writable, executable, user}); end
    n_cmp++; if (zero_page !== 1'b0) begin n_err++; $display("FAIL t1_zero_page: got %0b need 0", zero_page); end
    do_lookup(64'h1234_5ABC, 16'd6);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t1_asid_miss: got %0b need 0", hit); end
    n_cmp++; if (pa !== '0) begin n_err++; $display("FAIL t1_miss_pa: got %h need 0", pa); end
  endtask

  task automatic test_global_flush();
    int w;
    do_fill(64'h4020_0000, 16'd3, 64'hC000_0000, 1'b1, PG_2M, 1'b0, w);
    do_fill(64'h0AAA_A000, 16'd3, 64'h6000_0000, 1'b0, PG_4K, 1'b0, w);
    do_lookup(64'h403F_FFF0, 16'd7);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t2_gbl_hit: got %0b need 1", hit); end
    n_cmp++; if (pa !== 56'hC01F_FFF0) begin n_err++; $display("FAIL t2_gbl_pa: got %h need c01ffff0", pa); end
    do_lookup(64'h0AAA_A000, 16'd3);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t2_asid3_hit: got %0b need 1", hit); end
    do_flush(1'b0, 64'd0, 1'b1, 16'd3);
    do_lookup(64'h403F_FFF0, 16'd7);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t2_gbl_kept: got %0b need 1", hit); end
    do_lookup(64'h0AAA_A000, 16'd3);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t2_asid3_cleared: got %0b need 0", hit); end
    do_lookup(64'h1234_5ABC, 16'd5);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t2_asid5_kept: got %0b need 1", hit); end
    flush_req = 1'b1; flush_va_en = 1'b0; flush_asid_en = 1'b0;
    tick();
    flush_req = 1'b0;
    n_cmp++; if (flush_ack !== 1'b0 || replace_ready !== 1'b0) begin n_err++; $display("FAIL t2_cyc1: ack/ready got %0b/%0b need 0/0", flush_ack, replace_ready); end
    tick();
    n_cmp++; if (flush_ack !== 1'b1 || replace_ready !== 1'b0) begin n_err++; $display("FAIL t2_cyc2: ack/ready got %0b/%0b need 1/0", flush_ack, replace_ready); end
    tick();
    n_cmp++; if (flush_ack !== 1'b0 || replace_ready !== 1'b1) begin n_err++; $display("FAIL t2_cyc3: ack/ready got %0b/%0b need 0/1", flush_ack, replace_ready); end
    do_lookup(64'h403F_FFF0, 16'd7);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t2_gbl_flushed: got %0b need 0", hit); end
    do_lookup(64'h1234_5ABC, 16'd5);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t2_all_flushed: got %0b need 0", hit); end
  endtask

  task automatic test_plru();
    int w;
    logic [63:0] lva;
    for (int k = 0; k < 4; k++) begin
      lva = 64'h0010_0000 + 64'(k) * 64'h1000;
      do_fill(lva, 16'd1, 64'h2000_0000 + 64'(k) * 64'h1000, 1'b0, PG_4K, 1'b0, w);
    end
    foreach (lva[i]) begin end
    for (int j = 0; j < 3; j++) begin
      lva = (j == 0) ? 64'h0010_0000 : (j == 1) ? 64'h0010_2000 : 64'h0010_1000;
      do_lookup(lva, 16'd1);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t3_touch%0d: got %0b need 1", j, hit); end
    end
    do_fill(64'h0066_6000, 16'd1, 64'h3100_0000, 1'b0, PG_4K, 1'b1, w);
    do_fill(64'h0077_7000, 16'd1, 64'h3000_0000, 1'b0, PG_4K, 1'b0, w);
    do_lookup(64'h0077_7010, 16'd1);
    n_cmp++; if (hit !== 1'b1 || pa !== 56'h3000_0010) begin n_err++; $display("FAIL t3_new: hit/pa got %0b/%h need 1/30000010", hit, pa); end
    do_lookup(64'h0010_3000, 16'd1);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t3_evict3: got %0b need 0", hit); end
    for (int k = 0; k < 3; k++) begin
      do_lookup(64'h0010_0000 + 64'(k) * 64'h1000, 16'd1);
      n_cmp++; if (hit !== 1'b1 || pa !== PA_WIDTH'(64'h2000_0000 + 64'(k) * 64'h1000)) begin n_err++; $display("FAIL t3_keep%0d: hit/pa got %0b/%h", k, hit, pa); end
    end
    do_lookup(64'h0066_6000, 16'd1);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t3_fault_written: got %0b need 0", hit); end
  endtask

  task automatic test_back_to_back();
    int w;
    replace = 1'b1; replace_va = 64'h0055_5000; replace_asid = 16'd2;
    rsp.paddr = 64'h4000_0000; rsp.fault = 1'b0; rsp.gbl = 1'b0; rsp.pgsize = PG_4K; rsp.perm = fill_perm;
    flush_req = 1'b1; flush_va_en = 1'b1; flush_va = 64'h0055_5000; flush_asid_en = 1'b0;
    tick();
    replace = 1'b0; flush_req = 1'b0;
    n_cmp++; if (replace_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready1: got %0b need 0", replace_ready); end
    tick();
    n_cmp++; if (replace_ready !== 1'b0 || flush_ack !== 1'b1) begin n_err++; $display("FAIL t4_ready2: ready/ack got %0b/%0b need 0/1", replace_ready, flush_ack); end
    tick();
    n_cmp++; if (replace_ready !== 1'b1) begin n_err++; $display("FAIL t4_ready3: got %0b need 1", replace_ready); end
    do_lookup(64'h0055_5000, 16'd2);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t4_fill_flushed: got %0b need 0", hit); end
    do_lookup(64'h0077_7010, 16'd1);
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL t4_other_kept: got %0b need 1", hit); end
    replace = 1'b1; replace_va = 64'h0088_8000; rsp.paddr = 64'h4100_0000;
    flush_req = 1'b1; flush_va_en = 1'b1; flush_va = 64'h0099_9000;
    tick();
    replace = 1'b0; flush_req = 1'b0;
    tick(); tick();
    do_lookup(64'h0088_8044, 16'd2);
    n_cmp++; if (hit !== 1'b1 || pa !== 56'h4100_0044) begin n_err++; $display("FAIL t4_fill_survives: hit/pa got %0b/%h need 1/41000044", hit, pa); end
    flush_req = 1'b1; flush_va_en = 1'b0; flush_asid_en = 1'b0;
    tick();
    flush_req = 1'b0;
    do_fill(64'h0033_3000, 16'd4, 64'h7000_0000, 1'b0, PG_4K, 1'b0, w);
    n_cmp++; if (w !== 2) begin n_err++; $display("FAIL t4_held_wait: got %0d cycles need 2", w); end
    do_lookup(64'h0033_3008, 16'd4);
    n_cmp++; if (hit !== 1'b1 || pa !== 56'h7000_0008) begin n_err++; $display("FAIL t4_held_fill: hit/pa got %0b/%h need 1/70000008", hit, pa); end
    do_lookup(64'h0077_7010, 16'd1);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t4_full_flush: got %0b need 0", hit); end
  endtask

  task automatic test_reset_mid_flush();
    do_lookup(64'h0033_3008, 16'd4);
    flush_req = 1'b1; flush_va_en = 1'b0; flush_asid_en = 1'b0;
    tick();
    flush_req = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if (hit !== 1'b0 || pa !== '0) begin n_err++; $display("FAIL t5_out: hit/pa got %0b/%h need 0/0", hit, pa); end
    n_cmp++; if ({dirty, readable, writable, executable, user, zero_page} !== 6'b0) begin n_err++; $display("FAIL t5_perm: got %b need 000000", {dirty, readable, writable, executable, user, zero_page}); end
    n_cmp++; if (tlb_accesses !== 64'd0 || tlb_hits !== 64'd0) begin n_err++; $display("FAIL t5_cnt: got %0d/%0d need 0/0", tlb_accesses, tlb_hits); end
    tick();
    n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL t5_ack_in_rst: got %0b need 0", flush_ack); end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (flush_ack !== 1'b0) begin n_err++; $display("FAIL t5_ack_after%0d: got %0b need 0", c, flush_ack); end
    end
    n_cmp++; if (replace_ready !== 1'b1) begin n_err++; $display("FAIL t5_idle: got %0b need 1", replace_ready); end
    do_lookup(64'h0033_3008, 16'd4);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL t5_lookup_miss: got %0b need 0", hit); end
  endtask

  task automatic test_perf_cnt();
    int w;
    // Reset left both counters at 0; the miss lookup above made one access
`ifdef TLB_PERF_CNT_EN
    exp_acc = 64'd11; exp_hits = 64'd7;
`else
    exp_acc = 64'd0;  exp_hits = 64'd0;
`endif
    do_fill(64'h0012_3000, 16'd1, 64'h5000_0000, 1'b0, PG_4K, 1'b0, w);
    for (int k = 0; k < 7; k++) do_lookup(64'h0012_3000 + 64'(k), 16'd1);
    for (int k = 0; k < 3; k++) do_lookup(64'h0ABC_D000, 16'd1);
    n_cmp++; if (tlb_accesses !== exp_acc) begin n_err++; $display("FAIL t6_accesses: got %0d need %0d", tlb_accesses, exp_acc); end
    n_cmp++; if (tlb_hits !== exp_hits) begin n_err++; $display("FAIL t6_hits: got %0d need %0d", tlb_hits, exp_hits); end
  endtask

  task automatic test_bypass();
    active = 1'b0;
    do_lookup(64'h0000_00AB_CDEF_1234, 16'd9);
    n_cmp++; if (hit !== 1'b1 || pa !== 56'h00_00AB_CDEF_1234) begin n_err++; $display("FAIL bypass_pa: hit/pa got %0b/%h need 1/abcdef1234", hit, pa); end
    do_lookup(64'h0000_0000_0000_0123, 16'd9);
    n_cmp++; if (zero_page !== 1'b1 || pa !== 56'h123) begin n_err++; $display("FAIL bypass_zero_page: zp/pa got %0b/%h need 1/123", zero_page, pa); end
    n_cmp++; if (tlb_accesses !== exp_acc) begin n_err++; $display("FAIL bypass_no_count: got %0d need %0d", tlb_accesses, exp_acc); end
    active = 1'b1;
  endtask

  initial begin
    reset = 1'b0; priv = 2'd0; active = 1'b1; req = 1'b0; va = '0; asid = '0;
    replace = 1'b0; replace_va = '0; replace_asid = '0; rsp = '0;
    flush_req = 1'b0; flush_va_en = 1'b0; flush_va = '0; flush_asid_en = 1'b0; flush_asid = '0;
    fill_perm = '0; exp_acc = '0; exp_hits = '0;
    test_reset();
    test_basic_lookup();
    test_global_flush();
    test_plru();
    test_back_to_back();
    test_reset_mid_flush();
    test_perf_cnt();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
